alu_pc_unit: RTL and testbench

ALU_PC_UNIT -- requirements
Module: alu_pc_unit

---
 rtl/alu_pc_unit_if.sv | 38 +++
 rtl/alu_pc_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_pc_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pc_unit_if.sv
// Bundle of ALU operands/flags and program-counter controls shared between alu_pc_unit and its host.
// The DUT uses the slave modport; the driving side uses master.
interface alu_pc_unit_if;
  logic [7:0] a;
  logic [7:0] b;
  logic       carryIn;
  logic       overflowIn;
  logic [3:0] operation;
  logic [7:0] f;
  logic       negative;
  logic       overflow;
  logic       zero;
  logic       carry;

  logic       load_pc_l;
  logic       load_pc_h;
  logic       L_inc;
  logic       H_inc;
  logic [7:0] PCL_in;
  logic [7:0] PCH_in;
  logic [7:0] PCL_out;
  logic [7:0] PCH_out;
  logic       PCL_carry;

  modport master (
    output a, b, carryIn, overflowIn, operation,
    output load_pc_l, load_pc_h, L_inc, H_inc, PCL_in, PCH_in,
    input  f, negative, overflow, zero, carry,
    input  PCL_out, PCH_out, PCL_carry
  );

  modport slave (
    input  a, b, carryIn, overflowIn, operation,
    input  load_pc_l, load_pc_h, L_inc, H_inc, PCL_in, PCH_in,
    output f, negative, overflow, zero, carry,
    output PCL_out, PCH_out, PCL_carry
  );
endinterface

// File: rtl/alu_pc_unit.sv
// 8-bit binary ALU (purely combinational) plus a 16-bit program counter {PCH,PCL}
// with per-byte load, linear increment and page increment.
module alu_pc_unit (
  input  logic          clk,
  input  logic          rst_n,
  alu_pc_unit_if.slave  bus_if
);

  typedef enum logic [3:0] {
    OP_ADC  = 4'h0,
    OP_SBC  = 4'h1,
    OP_AND  = 4'h2,
    OP_ORA  = 4'h3,
    OP_EOR  = 4'h4,
    OP_ASL  = 4'h5,
    OP_LSR  = 4'h6,
    OP_ROL  = 4'h7,
    OP_ROR  = 4'h8,
    OP_INC  = 4'h9,
    OP_DEC  = 4'hA,
    OP_CMP  = 4'hB,
    OP_BIT  = 4'hC,
    OP_PSA  = 4'hD,
    OP_PSB  = 4'hE,
    OP_ADD  = 4'hF
  } alu_op_e;

  alu_op_e    op;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       vin;

  logic [8:0] sum;
  logic [7:0] res;
  logic       c_flag;
  logic       v_flag;
  logic       n_flag;
  logic       z_flag;

  assign op  = alu_op_e'(bus_if.operation);
  assign a   = bus_if.a;
  assign b   = bus_if.b;
  assign cin = bus_if.carryIn;
  assign vin = bus_if.overflowIn;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, otherwise an unlisted path holds the old value and infers a latch.
    sum    = 9'd0;
    res    = a;
    c_flag = cin;
    v_flag = vin;

    unique case (op)
      OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        res    = sum[7:0];
        c_flag = sum[8];
        v_flag = (a[7] == b[7]) && (res[7] != a[7]);
      end
      OP_SBC: begin
        // Subtraction as a + ~b + cin: carry out means "no borrow".
        sum    = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
        res    = sum[7:0];
        c_flag = sum[8];
        v_flag = (a[7] != b[7]) && (res[7] != a[7]);
      end
      OP_AND: res = a & b;
      OP_ORA: res = a | b;
      OP_EOR: res = a ^ b;
      OP_ASL: begin
        res    = {a[6:0], 1'b0};
        c_flag = a[7];
      end
      OP_LSR: begin
        res    = {1'b0, a[7:1]};
        c_flag = a[0];
      end
      OP_ROL: begin
        res    = {a[6:0], cin};
        c_flag = a[7];
      end
      OP_ROR: begin
        res    = {cin, a[7:1]};
        c_flag = a[0];
      end
      OP_INC: res = a + 8'd1;
      OP_DEC: res = a - 8'd1;
      OP_CMP: begin
        sum    = {1'b0, a} + {1'b0, ~b} + 9'd1;
        res    = sum[7:0];
        c_flag = sum[8];
      end
      OP_BIT: begin
        res    = a & b;
        v_flag = b[6];
      end
      OP_PSA: res = a;
      OP_PSB: res = b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        res    = sum[7:0];
        c_flag = sum[8];
      end
      default: res = a;
    endcase
  end

  // BIT reports operand B's sign rather than the result's.
  assign n_flag = (op == OP_BIT) ? b[7] : res[7];
  assign z_flag = (res == 8'h00);

  assign bus_if.f        = res;
  assign bus_if.negative = n_flag;
  assign bus_if.overflow = v_flag;
  assign bus_if.zero     = z_flag;
  assign bus_if.carry    = c_flag;

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  logic [7:0] pcl_q, pcl_d;
  logic [7:0] pch_q, pch_d;
  logic       pcl_carry;

  assign pcl_carry = bus_if.L_inc && (pcl_q == 8'hFF);

  // Each byte resolves independently: its load wins, otherwise its increments apply.
  always_comb begin
    pcl_d = pcl_q;
    pch_d = pch_q;

    if (bus_if.load_pc_l) begin
      pcl_d = bus_if.PCL_in;
    end else if (bus_if.L_inc) begin
      pcl_d = pcl_q + 8'd1;
    end

    if (bus_if.load_pc_h) begin
      pch_d = bus_if.PCH_in;
    end else begin
      pch_d = pch_q + {7'd0, bus_if.H_inc} + {7'd0, pcl_carry};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcl_q <= 8'h00;
      pch_q <= 8'h00;
    end else begin
      pcl_q <= pcl_d;
      pch_q <= pch_d;
    end
  end

  assign bus_if.PCL_out   = pcl_q;
  assign bus_if.PCH_out   = pch_q;
  assign bus_if.PCL_carry = pcl_carry;

endmodule

// File: tb/tb_alu_pc_unit.sv
// Directed self-checking bench for alu_pc_unit: ALU opcode vectors, PC load/increment
// rules and asynchronous reset behaviour.
module tb_alu_pc_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_pc_unit_if bus_if ();

  alu_pc_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive an ALU vector on the falling edge and let it settle.
  task automatic drive_alu(input logic [3:0] op, input logic [7:0] a_v, input logic [7:0] b_v,
                           input logic cin, input logic vin);
    @(negedge clk);
    bus_if.operation  = op;
    bus_if.a          = a_v;
    bus_if.b          = b_v;
    bus_if.carryIn    = cin;
    bus_if.overflowIn = vin;
    #1;
  endtask

  task automatic clear_pc_ctrl();
    bus_if.load_pc_l = 1'b0;
    bus_if.load_pc_h = 1'b0;
    bus_if.L_inc     = 1'b0;
    bus_if.H_inc     = 1'b0;
  endtask

  // Load a full PC value with one clock edge.
  task automatic load_pc(input logic [15:0] v);
    @(negedge clk);
    clear_pc_ctrl();
    bus_if.load_pc_l = 1'b1;
    bus_if.load_pc_h = 1'b1;
    bus_if.PCH_in    = v[15:8];
    bus_if.PCL_in    = v[7:0];
    @(posedge clk);
    #1;
    clear_pc_ctrl();
  endtask

  // Apply one cycle of controls (loads use the given data) and sample after the edge.
  task automatic step_pc(input logic ll, input logic lh, input logic li, input logic hi,
                         input logic [7:0] pcl_in, input logic [7:0] pch_in);
    @(negedge clk);
    bus_if.load_pc_l = ll;
    bus_if.load_pc_h = lh;
    bus_if.L_inc     = li;
    bus_if.H_inc     = hi;
    bus_if.PCL_in    = pcl_in;
    bus_if.PCH_in    = pch_in;
    @(posedge clk);
    #1;
    clear_pc_ctrl();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_pc_ctrl();
    bus_if.PCL_in = 8'h00;
    bus_if.PCH_in = 8'h00;
    drive_alu(4'hD, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 0000", {bus_if.PCH_out, bus_if.PCL_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release_hold: got %h expected 0000", {bus_if.PCH_out, bus_if.PCL_out});
    end
  endtask

  // Each ALU vector: {op, a, b, cin, vin} -> {f, N, V, Z, C}.
  task automatic test_alu();
    logic [3:0]  ops  [18];
    logic [7:0]  av   [18];
    logic [7:0]  bv   [18];
    logic [1:0]  cv   [18];
    logic [11:0] exp  [18];
    logic [11:0] got;
    ops[0]  = 4'h0; av[0]  = 8'h50; bv[0]  = 8'h50; cv[0]  = 2'b00; exp[0]  = {8'hA0, 4'b1100};
    ops[1]  = 4'h0; av[1]  = 8'hFF; bv[1]  = 8'h01; cv[1]  = 2'b00; exp[1]  = {8'h00, 4'b0011};
    ops[2]  = 4'h1; av[2]  = 8'h00; bv[2]  = 8'h01; cv[2]  = 2'b10; exp[2]  = {8'hFF, 4'b1000};
    ops[3]  = 4'hB; av[3]  = 8'h05; bv[3]  = 8'h05; cv[3]  = 2'b01; exp[3]  = {8'h00, 4'b0111};
    ops[4]  = 4'hB; av[4]  = 8'h03; bv[4]  = 8'h05; cv[4]  = 2'b10; exp[4]  = {8'hFE, 4'b1000};
    ops[5]  = 4'h8; av[5]  = 8'h01; bv[5]  = 8'h00; cv[5]  = 2'b10; exp[5]  = {8'h80, 4'b1001};
    ops[6]  = 4'h7; av[6]  = 8'h80; bv[6]  = 8'h00; cv[6]  = 2'b00; exp[6]  = {8'h00, 4'b0011};
    ops[7]  = 4'h5; av[7]  = 8'h81; bv[7]  = 8'h00; cv[7]  = 2'b00; exp[7]  = {8'h02, 4'b0001};
    ops[8]  = 4'h6; av[8]  = 8'h01; bv[8]  = 8'h00; cv[8]  = 2'b01; exp[8]  = {8'h00, 4'b0111};
    ops[9]  = 4'hC; av[9]  = 8'h0F; bv[9]  = 8'hC0; cv[9]  = 2'b00; exp[9]  = {8'h00, 4'b1110};
    ops[10] = 4'h2; av[10] = 8'hF0; bv[10] = 8'h3C; cv[10] = 2'b11; exp[10] = {8'h30, 4'b0101};
    ops[11] = 4'h3; av[11] = 8'h0F; bv[11] = 8'hF0; cv[11] = 2'b00; exp[11] = {8'hFF, 4'b1000};
    ops[12] = 4'h4; av[12] = 8'hAA; bv[12] = 8'hAA; cv[12] = 2'b10; exp[12] = {8'h00, 4'b0011};
    ops[13] = 4'h9; av[13] = 8'hFF; bv[13] = 8'h00; cv[13] = 2'b01; exp[13] = {8'h00, 4'b0110};
    ops[14] = 4'hA; av[14] = 8'h00; bv[14] = 8'h00; cv[14] = 2'b10; exp[14] = {8'hFF, 4'b1001};
    ops[15] = 4'hD; av[15] = 8'h7F; bv[15] = 8'h80; cv[15] = 2'b00; exp[15] = {8'h7F, 4'b0000};
    ops[16] = 4'hE; av[16] = 8'h7F; bv[16] = 8'h80; cv[16] = 2'b01; exp[16] = {8'h80, 4'b1100};
    ops[17] = 4'hF; av[17] = 8'h80; bv[17] = 8'h80; cv[17] = 2'b10; exp[17] = {8'h00, 4'b0011};
    for (int i = 0; i < 18; i++) begin
      drive_alu(ops[i], av[i], bv[i], cv[i][1], cv[i][0]);
      got = {bus_if.f, bus_if.negative, bus_if.overflow, bus_if.zero, bus_if.carry};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL alu_vec%0d op=%h a=%h b=%h: got f=%h NVZC=%b expected f=%h NVZC=%b",
                 i, ops[i], av[i], bv[i], got[11:4], got[3:0], exp[i][11:4], exp[i][3:0]);
      end
    end
  endtask

  task automatic test_pc_linc();
    load_pc(16'h12FF);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h12FF) begin
      errors++;
      $display("FAIL pc_load: got %h expected 12FF", {bus_if.PCH_out, bus_if.PCL_out});
    end
    @(negedge clk);
    bus_if.L_inc = 1'b1;
    #1;
    checks++;
    if (bus_if.PCL_carry !== 1'b1) begin
      errors++;
      $display("FAIL pcl_carry_before_edge: got %b expected 1", bus_if.PCL_carry);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h1300) begin
      errors++;
      $display("FAIL pc_linc_carry: got %h expected 1300", {bus_if.PCH_out, bus_if.PCL_out});
    end
    checks++;
    if (bus_if.PCL_carry !== 1'b0) begin
      errors++;
      $display("FAIL pcl_carry_after: got %b expected 0", bus_if.PCL_carry);
    end
    clear_pc_ctrl();
    load_pc(16'hFFFF);
    step_pc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0000) begin
      errors++;
      $display("FAIL pc_wrap: got %h expected 0000", {bus_if.PCH_out, bus_if.PCL_out});
    end
  endtask

  task automatic test_pc_hinc();
    load_pc(16'h1234);
    step_pc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h1334) begin
      errors++;
      $display("FAIL pc_hinc: got %h expected 1334", {bus_if.PCH_out, bus_if.PCL_out});
    end
    load_pc(16'hFF12);
    step_pc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0012) begin
      errors++;
      $display("FAIL pc_hinc_wrap: got %h expected 0012", {bus_if.PCH_out, bus_if.PCL_out});
    end
    load_pc(16'h12FF);
    step_pc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h1400) begin
      errors++;
      $display("FAIL pc_both_inc: got %h expected 1400", {bus_if.PCH_out, bus_if.PCL_out});
    end
  endtask

  task automatic test_pc_priority();
    load_pc(16'h12FF);
    step_pc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hAB);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'hAB00) begin
      errors++;
      $display("FAIL pc_loadh_over_carry: got %h expected AB00", {bus_if.PCH_out, bus_if.PCL_out});
    end
    load_pc(16'h12FF);
    step_pc(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'h00);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h1355) begin
      errors++;
      $display("FAIL pc_loadl_with_linc: got %h expected 1355", {bus_if.PCH_out, bus_if.PCL_out});
    end
    step_pc(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 8'hEE);
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h1355) begin
      errors++;
      $display("FAIL pc_hold: got %h expected 1355", {bus_if.PCH_out, bus_if.PCL_out});
    end
  endtask

  task automatic test_back_to_back();
    load_pc(16'h00FE);
    @(negedge clk);
    bus_if.L_inc = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h00FF) begin
      errors++;
      $display("FAIL b2b_first: got %h expected 00FF", {bus_if.PCH_out, bus_if.PCL_out});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_second: got %h expected 0100", {bus_if.PCH_out, bus_if.PCL_out});
    end
    clear_pc_ctrl();
  endtask

  task automatic test_async_reset();
    load_pc(16'h5678);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_no_edge: got %h expected 0000", {bus_if.PCH_out, bus_if.PCL_out});
    end
    // ALU stays live during reset.
    drive_alu(4'h0, 8'h01, 8'h02, 1'b1, 1'b0);
    checks++;
    if (bus_if.f !== 8'h04) begin
      errors++;
      $display("FAIL alu_during_reset: got %h expected 04", bus_if.f);
    end
    bus_if.L_inc = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_held_over_edge: got %h expected 0000", {bus_if.PCH_out, bus_if.PCL_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0000) begin
      errors++;
      $display("FAIL release_before_edge: got %h expected 0000", {bus_if.PCH_out, bus_if.PCL_out});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus_if.PCH_out, bus_if.PCL_out} !== 16'h0001) begin
      errors++;
      $display("FAIL first_edge_after_release: got %h expected 0001", {bus_if.PCH_out, bus_if.PCL_out});
    end
    clear_pc_ctrl();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_pc_linc();
    test_pc_hinc();
    test_pc_priority();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
